// File: rtl/rheed_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rheed_pkg
// Description : Shared types, record bit positions and the record builder for
//               the RHEED result packing path.
// Revision    : 1.0 - initial release
// ============================================================================
package rheed_pkg;

    localparam int RESULT_W  = 22;
    localparam int N_RESULTS = 5;
    localparam int SEQ_W     = 15;
    localparam int REC_W     = 128;

    // Record bit positions: valid flag, sequence number, two zero pad bits,
    // then the five results packed with d[0] in the least significant slot.
    localparam int REC_VALID_BIT = 127;
    localparam int REC_SEQ_MSB   = 126;
    localparam int REC_SEQ_LSB   = 112;
    localparam int REC_DATA_W    = RESULT_W * N_RESULTS;

    typedef logic [RESULT_W-1:0] result_t;

    // Builds one 128-bit record from a result vector and its sequence tag.
    function automatic logic [REC_W-1:0] make_record(
        input result_t          d [N_RESULTS],
        input logic [SEQ_W-1:0] seq,
        input logic             valid
    );
        logic [REC_W-1:0] rec;
        rec = '0;
        rec[REC_VALID_BIT]             = valid;
        rec[REC_SEQ_MSB:REC_SEQ_LSB]   = seq;
        for (int i = 0; i < N_RESULTS; i++) begin
            rec[i*RESULT_W +: RESULT_W] = d[i];
        end
        return rec;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rheed_result_packer.sv
`default_nettype none
// ============================================================================
// Module      : rheed_result_packer
// Description : Packs 5x22-bit CNN result vectors into 128-bit tagged records,
//               two records per 256-bit AXI-Stream word. A held lone record is
//               emitted as a half word on flush or after an idle timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module rheed_result_packer
    import rheed_pkg::*;
#(
    parameter int BURST_WORDS   = 16,
    parameter int FLUSH_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  result_t            s_axis_tdata [N_RESULTS],
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic [2*REC_W-1:0] m_axis_tdata,
    output logic               m_axis_tlast,
    output logic [SEQ_W-1:0]   seq_num
);

    localparam int c_WORD_W  = 2 * REC_W;
    localparam int c_BURST_W = (BURST_WORDS < 2) ? 1 : $clog2(BURST_WORDS);
    localparam int c_TMO_W   = (FLUSH_TIMEOUT < 2) ? 1 : $clog2(FLUSH_TIMEOUT);
    localparam bit c_TMO_EN  = (FLUSH_TIMEOUT != 0);

    localparam logic [c_BURST_W-1:0] c_BURST_LAST = c_BURST_W'(BURST_WORDS - 1);
    localparam logic [c_TMO_W-1:0]   c_TMO_LAST   =
        c_TMO_W'((FLUSH_TIMEOUT == 0) ? 0 : FLUSH_TIMEOUT - 1);

    // Registered state
    logic [REC_W-1:0]    r_hold_rec;
    logic                r_hold_valid;
    logic                r_flush_pend;
    logic [c_TMO_W-1:0]  r_tmo_cnt;
    logic [c_BURST_W-1:0] r_burst_cnt;
    logic [SEQ_W-1:0]    r_seq;
    logic                r_out_valid;
    logic                r_out_last;
    logic [c_WORD_W-1:0] r_out_data;

    // Next-state values
    logic [REC_W-1:0]    w_hold_rec_nxt;
    logic                w_hold_valid_nxt;
    logic                w_flush_pend_nxt;
    logic [c_TMO_W-1:0]  w_tmo_cnt_nxt;
    logic [c_BURST_W-1:0] w_burst_cnt_nxt;
    logic [SEQ_W-1:0]    w_seq_nxt;
    logic                w_out_valid_nxt;
    logic                w_out_last_nxt;
    logic [c_WORD_W-1:0] w_out_data_nxt;

    // Handshake and decision terms
    logic                w_out_free;
    logic                w_s_ready;
    logic                w_beat;
    logic                w_out_hs;
    logic                w_tmo_hit;
    logic                w_do_flush;
    logic [REC_W-1:0]    w_new_rec;

    // Handshakes, flush decision and next values for every register.
    always_comb begin
        w_out_free = !r_out_valid || m_axis_tready;
        // Only a held record needs the output path, so EMPTY always accepts.
        w_s_ready  = !r_hold_valid || w_out_free;
        w_beat     = s_axis_tvalid && w_s_ready;
        w_out_hs   = r_out_valid && m_axis_tready;
        w_new_rec  = make_record(s_axis_tdata, r_seq, 1'b1);
        // >= keeps the timeout armed while the output register is blocked.
        w_tmo_hit  = c_TMO_EN && (r_tmo_cnt >= c_TMO_LAST);
        // A beat in HALF always wins over a flush of the held record.
        w_do_flush = r_hold_valid && !w_beat && w_out_free &&
                     (flush || r_flush_pend || w_tmo_hit);

        w_hold_rec_nxt   = r_hold_rec;
        w_hold_valid_nxt = r_hold_valid;
        w_flush_pend_nxt = r_flush_pend;
        w_tmo_cnt_nxt    = r_tmo_cnt;
        w_burst_cnt_nxt  = r_burst_cnt;
        w_seq_nxt        = r_seq;
        w_out_valid_nxt  = r_out_valid;
        w_out_last_nxt   = r_out_last;
        w_out_data_nxt   = r_out_data;

        // The burst position advances on each delivered word, so a word loaded
        // in the same cycle as a handshake sees the post-handshake count.
        if (w_out_hs) begin
            w_out_valid_nxt = 1'b0;
            if (r_out_last) begin
                w_burst_cnt_nxt = '0;
            end else begin
                w_burst_cnt_nxt = r_burst_cnt + 1'b1;
            end
        end

        if (w_beat) begin
            w_seq_nxt = r_seq + 1'b1;
        end

        if (w_beat && !r_hold_valid) begin
            w_hold_rec_nxt   = w_new_rec;
            w_hold_valid_nxt = 1'b1;
        end else if (w_beat) begin
            w_out_data_nxt   = {w_new_rec, r_hold_rec};
            w_out_last_nxt   = (w_burst_cnt_nxt == c_BURST_LAST);
            w_out_valid_nxt  = 1'b1;
            w_hold_valid_nxt = 1'b0;
            w_flush_pend_nxt = 1'b0;
        end else if (w_do_flush) begin
            w_out_data_nxt   = {{REC_W{1'b0}}, r_hold_rec};
            w_out_last_nxt   = 1'b1;
            w_out_valid_nxt  = 1'b1;
            w_hold_valid_nxt = 1'b0;
            w_flush_pend_nxt = 1'b0;
        end else if (flush && r_hold_valid) begin
            w_flush_pend_nxt = 1'b1;
        end

        // Idle age of the held record; zero on entry to and exit from HALF.
        if (r_hold_valid && w_hold_valid_nxt) begin
            if (r_tmo_cnt != '1) begin
                w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
            end
        end else begin
            w_tmo_cnt_nxt = '0;
        end
    end

    // State register with synchronous reset; any held or pending data is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_rec   <= '0;
            r_hold_valid <= 1'b0;
            r_flush_pend <= 1'b0;
            r_tmo_cnt    <= '0;
            r_burst_cnt  <= '0;
            r_seq        <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_data   <= '0;
        end else begin
            r_hold_rec   <= w_hold_rec_nxt;
            r_hold_valid <= w_hold_valid_nxt;
            r_flush_pend <= w_flush_pend_nxt;
            r_tmo_cnt    <= w_tmo_cnt_nxt;
            r_burst_cnt  <= w_burst_cnt_nxt;
            r_seq        <= w_seq_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_out_last   <= w_out_last_nxt;
            r_out_data   <= w_out_data_nxt;
        end
    end

    assign s_axis_tready = w_s_ready;
    assign m_axis_tvalid = r_out_valid;
    assign m_axis_tdata  = r_out_data;
    assign m_axis_tlast  = r_out_last;
    assign seq_num       = r_seq;

endmodule
`default_nettype wire

// File: tb/tb_rheed_result_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rheed_result_packer
// Description : Scoreboard bench for rheed_result_packer: a record-level
//               reference model predicts every output word, a monitor checks
//               delivered words, and directed sequences cover the corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rheed_result_packer;
    import rheed_pkg::*;

    localparam int B = 4;
    localparam int F = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic         s_valid = 1'b0;
    logic         m_ready = 1'b0;
    result_t      s_data [N_RESULTS];
    logic         s_axis_tready;
    logic         m_axis_tvalid;
    logic [255:0] m_axis_tdata;
    logic         m_axis_tlast;
    logic [14:0]  seq_num;

    always #5 clk = ~clk;

    rheed_result_packer #(.BURST_WORDS(B), .FLUSH_TIMEOUT(F)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_data),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .seq_num       (seq_num)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [255:0] data;
        bit           last;
    } word_t;

    word_t        exp_q[$];
    logic [127:0] m_held[$];
    bit           m_out_valid = 0;
    bit           m_cur_last  = 0;
    bit           m_pend      = 0;
    int           m_burst     = 0;
    logic [14:0]  m_seq       = '0;
    longint       m_edge      = 0;
    longint       m_acc_edge  = 0;

    function automatic logic [127:0] ref_record(input result_t d [N_RESULTS], input logic [14:0] s);
        return {1'b1, s, 2'b00, d[4], d[3], d[2], d[1], d[0]};
    endfunction

    // Predicts what the coming clock edge does from the inputs now on the bus.
    always @(negedge clk) begin
        bit    out_free, half, exp_ready, beat, tmo, load;
        word_t w;
        if (reset) begin
            exp_q.delete();
            m_held.delete();
            m_out_valid = 0;
            m_cur_last  = 0;
            m_pend      = 0;
            m_burst     = 0;
            m_seq       = '0;
        end else begin
            out_free  = !m_out_valid || m_ready;
            half      = (m_held.size() != 0);
            exp_ready = !half || out_free;
            chk("tvalid", 256'(m_axis_tvalid), 256'(m_out_valid));
            chk("s_tready", 256'(s_axis_tready), 256'(exp_ready));
            chk("seq_num", 256'(seq_num), 256'(m_seq));
            beat = s_valid && exp_ready;
            load = 0;
            if (m_out_valid && m_ready) begin
                m_burst     = m_cur_last ? 0 : m_burst + 1;
                m_out_valid = 0;
            end
            tmo = half && (F != 0) && ((m_edge - m_acc_edge) >= F);
            if (beat) begin
                logic [127:0] rec;
                rec   = ref_record(s_data, m_seq);
                m_seq = m_seq + 15'd1;
                if (!half) begin
                    m_held.push_back(rec);
                    m_acc_edge = m_edge;
                end else begin
                    w.data = {rec, m_held.pop_front()};
                    w.last = (m_burst == B - 1);
                    load   = 1;
                end
            end else if (half && out_free && (flush || m_pend || tmo)) begin
                w.data = {128'b0, m_held.pop_front()};
                w.last = 1;
                load   = 1;
            end else if (half && flush) begin
                m_pend = 1;
            end
            if (load) begin
                exp_q.push_back(w);
                m_out_valid = 1;
                m_cur_last  = w.last;
                m_pend      = 0;
            end
        end
        m_edge++;
    end

    // ---------------- monitor ----------------
    logic [255:0] obs_data[$];
    bit           obs_last[$];

    // Every delivered word is compared against the oldest predicted word.
    always @(negedge clk) begin
        if (!reset && m_axis_tvalid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 256'(1), 256'(0));
            end else begin
                word_t w;
                w = exp_q.pop_front();
                chk("word_data", m_axis_tdata, w.data);
                chk("word_last", 256'(m_axis_tlast), 256'(w.last));
            end
            obs_data.push_back(m_axis_tdata);
            obs_last.push_back(m_axis_tlast);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_data(input logic [109:0] flat);
        for (int i = 0; i < N_RESULTS; i++) s_data[i] = flat[i*22 +: 22];
    endtask

    function automatic logic [109:0] rand_flat();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[109:0];
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset   = 1'b1;
        s_valid = 1'b0;
        flush   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        obs_data.delete();
        obs_last.delete();
    endtask

    task automatic send_beat(input logic [109:0] flat, input bit with_flush);
        int n;
        n = 0;
        set_data(flat);
        s_valid = 1'b1;
        flush   = with_flush;
        forever begin
            @(negedge clk);
            if (s_axis_tready) break;
            n++;
            if (n > 200) begin
                chk("beat_accept_timeout", 256'(0), 256'(1));
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        flush   = 1'b0;
    endtask

    function automatic int last_bits();
        int v;
        v = 0;
        foreach (obs_last[i]) if (obs_last[i]) v |= (1 << i);
        return v;
    endfunction

    // ---------------- directed and random sequences ----------------
    initial begin
        logic [109:0] flat1;
        int c0, c1, n;
        bit got;

        for (int i = 0; i < N_RESULTS; i++) s_data[i] = '0;
        do_reset();

        // Reset values
        @(negedge clk);
        chk("rst_tvalid", 256'(m_axis_tvalid), 256'(0));
        chk("rst_tlast", 256'(m_axis_tlast), 256'(0));
        chk("rst_tdata", m_axis_tdata, 256'(0));
        chk("rst_s_tready", 256'(s_axis_tready), 256'(1));
        chk("rst_seq", 256'(seq_num), 256'(0));
        @(posedge clk);
        #1;

        // Pairing
        m_ready = 1'b1;
        for (int i = 0; i < N_RESULTS; i++) flat1[i*22 +: 22] = 22'(i + 1);
        send_beat(flat1, 0);
        send_beat({5{22'h3FFFFF}}, 0);
        idle(3);
        chk("pair_count", 256'(obs_data.size()), 256'(1));
        if (obs_data.size() >= 1) begin
            chk("pair_v0", 256'(obs_data[0][127]), 256'(1));
            chk("pair_seq0", 256'(obs_data[0][126:112]), 256'(0));
            chk("pair_d0", 256'(obs_data[0][21:0]), 256'(1));
            chk("pair_v1", 256'(obs_data[0][255]), 256'(1));
            chk("pair_seq1", 256'(obs_data[0][254:240]), 256'(1));
            chk("pair_hi_d4", 256'(obs_data[0][237:216]), 256'(22'h3FFFFF));
            chk("pair_tlast", 256'(obs_last[0]), 256'(0));
        end

        // Burst tlast with no input bubbles
        do_reset();
        m_ready = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 8; k++) send_beat(rand_flat(), 0);
        c1 = cyc;
        chk("burst_no_bubble", 256'(c1 - c0), 256'(8));
        idle(3);
        chk("burst_count", 256'(obs_data.size()), 256'(4));
        chk("burst_tlast_pattern", 256'(last_bits()), 256'(4'b1000));

        // Explicit flush, then a full-length burst
        do_reset();
        m_ready = 1'b1;
        send_beat(rand_flat(), 0);
        idle(3);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_latency", 256'(m_axis_tvalid), 256'(1));
        @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) send_beat(rand_flat(), 0);
        idle(3);
        chk("flush_count", 256'(obs_data.size()), 256'(5));
        if (obs_data.size() >= 1) chk("flush_upper_zero", 256'(obs_data[0][255:128]), 256'(0));
        chk("flush_tlast_pattern", 256'(last_bits()), 256'(5'b10001));

        // Flush while EMPTY
        obs_data.delete();
        obs_last.delete();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("empty_flush_no_pend", 256'(dut.r_flush_pend), 256'(0));
        idle(12);
        chk("empty_flush_no_word", 256'(obs_data.size()), 256'(0));

        // Idle timeout latency
        do_reset();
        m_ready = 1'b1;
        set_data(rand_flat());
        s_valid = 1'b1;
        @(negedge clk);
        c0 = cyc;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        got = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (m_axis_tvalid) begin
                got = 1;
                break;
            end
        end
        c1 = cyc;
        chk("timeout_seen", 256'(got), 256'(1));
        chk("timeout_latency", 256'(c1 - c0), 256'(9));
        idle(3);

        // Backpressure with a deferred flush
        do_reset();
        m_ready = 1'b0;
        send_beat(rand_flat(), 0);
        send_beat(rand_flat(), 0);
        send_beat(rand_flat(), 0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("defer_pend_set", 256'(dut.r_flush_pend), 256'(1));
        chk("defer_blocked", 256'(m_axis_tvalid), 256'(1));
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(negedge clk);
        chk("defer_full_tlast", 256'(m_axis_tlast), 256'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("defer_half_valid", 256'(m_axis_tvalid), 256'(1));
        chk("defer_half_tlast", 256'(m_axis_tlast), 256'(1));
        chk("defer_half_upper", 256'(m_axis_tdata[255:128]), 256'(0));
        @(posedge clk);
        #1;
        idle(2);
        chk("defer_count", 256'(obs_data.size()), 256'(2));

        // Beat and flush in the same cycle
        do_reset();
        m_ready = 1'b1;
        send_beat(rand_flat(), 0);
        send_beat(rand_flat(), 1);
        idle(12);
        chk("collide_count", 256'(obs_data.size()), 256'(1));
        if (obs_data.size() >= 1) begin
            chk("collide_full", 256'(obs_data[0][255]), 256'(1));
            chk("collide_tlast", 256'(obs_last[0]), 256'(0));
        end

        // Reset while a record is held
        do_reset();
        send_beat(rand_flat(), 0);
        idle(2);
        do_reset();
        idle(12);
        chk("midreset_no_word", 256'(obs_data.size()), 256'(0));
        chk("midreset_seq", 256'(seq_num), 256'(0));

        // Sequence number wrap
        do_reset();
        m_ready = 1'b1;
        for (int k = 0; k < 32770; k++) send_beat(rand_flat(), 0);
        idle(3);
        chk("wrap_seq_out", 256'(seq_num), 256'(2));
        n = -1;
        foreach (obs_data[i]) if (obs_data[i][254:240] == 15'd32767 && n < 0) n = i;
        chk("wrap_found", 256'(n >= 0 && n + 1 < obs_data.size()), 256'(1));
        if (n >= 0 && n + 1 < obs_data.size()) begin
            chk("wrap_prev_seq", 256'(obs_data[n][126:112]), 256'(32766));
            chk("wrap_next_seq", 256'(obs_data[n+1][126:112]), 256'(0));
        end

        // Randomized traffic against the model
        do_reset();
        begin
            bit acc;
            acc = 1;
            for (int k = 0; k < 3000; k++) begin
                int seg, lim;
                seg = (k / 250) % 3;
                lim = (seg == 0) ? 1 : ((seg == 1) ? 16 : 40);
                if (!s_valid || acc) begin
                    s_valid = ($urandom_range(lim - 1, 0) == 0) || (seg == 0 && $urandom_range(1, 0) == 1);
                    set_data(rand_flat());
                end
                m_ready = ($urandom_range(3, 0) != 0);
                flush   = ($urandom_range(19, 0) == 0);
                @(negedge clk);
                acc = s_valid && s_axis_tready;
                @(posedge clk);
                #1;
            end
        end
        s_valid = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b1;
        idle(40);
        chk("scoreboard_drained", 256'(exp_q.size()), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Bound on total run time
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/rheed_result_packer.md
# rheed_result_packer

Packs the CNN regression output stream into 256-bit AXI-Stream words for the host-bound DMA path; this is the return direction of the 256-bit pixel ingress into `RHEED_inference`. Each accepted result vector (5 × 22-bit) becomes one 128-bit record tagged with a valid bit and a frame sequence number. Two records fill one output word. A flush input or an idle timeout emits half-filled words so that latency stays bounded at low frame rates.

## Interface
Parameters:
- `BURST_WORDS`, 16: number of output words per burst; `m_axis_tlast` marks the last word of a burst. Minimum 1.
- `FLUSH_TIMEOUT`, 1024: idle cycles with one record held before an automatic flush. A value of 0 disables the automatic flush.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high reset.
- `flush` in 1: single-cycle request to emit any held record now.
- `s_axis_tvalid` in 1: a result vector is valid.
- `s_axis_tready` out 1: the packer accepts the result vector.
- `s_axis_tdata` in 22 × [4:0]: unpacked array of 5 results, same layout as the CNN output.
- `m_axis_tvalid` out 1: an output word is valid.
- `m_axis_tready` in 1: downstream accepts the word.
- `m_axis_tdata` out 256: packed output word.
- `m_axis_tlast` out 1: end of burst, or a flushed word.
- `seq_num` out 15: sequence number that the next accepted record will carry.

## Operation
- **Record layout** (128 bits):
  - [127]: valid.
  - [126:112]: seq_num.
  - [111:110]: 0.
  - [109:0]: `{d[4],d[3],d[2],d[1],d[0]}`, with d[0] at [21:0].
- **Word layout:** the first record of a pair goes in [127:0], the second in [255:128].
- **Storage:** one hold register (lower record plus `hold_valid`) and one output register (`m_axis_tvalid`).
- **States:**
  - EMPTY: `!hold_valid`.
  - HALF: `hold_valid`.
  - Output-register occupancy is orthogonal to these states.
- **EMPTY:**
  - `s_axis_tready` = 1.
  - A beat is stored in the hold register, then go to HALF.
- **HALF:**
  - `s_axis_tready = !m_axis_tvalid || m_axis_tready`.
  - A beat forms the word {new record, held record} into the output register, then go to EMPTY.
- **Flush:** applies in HALF when no beat is accepted that cycle, the output register is free or draining, and either `flush` is high or the timeout counter is at `FLUSH_TIMEOUT-1`.
  - The output word is {128'b0, held record}.
  - `m_axis_tlast` = 1.
  - Go to EMPTY.
  - The burst word counter resets to 0.
- **Deferred flush:** if flush is requested but the output register is blocked, the request latches as `flush_pend` and fires at the first legal cycle. `flush_pend` clears when the held record is consumed by either path.
- **Flush in EMPTY:** no effect, and nothing is latched.
- **Simultaneous beat and flush in HALF:** the beat wins. A full word is emitted, `flush_pend` is cleared, and no half-word is sent.
- **Timeout counter:**
  - Counts cycles spent in HALF.
  - Clears on entering HALF and on leaving it.
  - Saturates; it does not wrap.
- **seq_num:** increments by 1 on every accepted input beat and wraps from 32767 to 0.
- **Burst word counter:**
  - Counts 0..BURST_WORDS-1 on each output word *handshake*.
  - `m_axis_tlast` is high when the counter equals BURST_WORDS-1 at the time the word is loaded, or when the word is a flushed word.
  - The counter resets after any handshake on a tlast word.
- **Output stability:** `m_axis_tdata`, `m_axis_tlast` and `m_axis_tvalid` stay stable while `m_axis_tvalid && !m_axis_tready`.

## Timing
- **Reset values:**
  - `m_axis_tvalid` = 0, `m_axis_tlast` = 0, `m_axis_tdata` = 0.
  - `s_axis_tready` = 1, because the block resets to EMPTY.
  - `seq_num` = 0.
  - `hold_valid`, `flush_pend`, the timeout counter and the burst counter all 0.
- **Reset mid-operation:** a held record or a pending output word is discarded, with no partial emission.
- **Full-word latency:** the second record is accepted at cycle t, and `m_axis_tvalid` rises at t+1.
- **Flush latency:**
  - `flush` at cycle t with the output free gives tvalid at t+1.
  - Auto flush: tvalid rises `FLUSH_TIMEOUT`+1 cycles after the held record was accepted.
- **Throughput:** 2 input beats per output word. With `m_axis_tready` held high there are no input bubbles.
- **Ready paths:**
  - No combinational path from `s_axis_tvalid` to `s_axis_tready`.
  - `m_axis_tready` → `s_axis_tready` is combinational, HALF only.

## Structure
- Package `rheed_pkg` holds:
  - `RESULT_W`=22, `N_RESULTS`=5, `SEQ_W`=15, `REC_W`=128.
  - The record bit-position constants.
  - `typedef logic [RESULT_W-1:0] result_t`.
  - The function `make_record(result_t d[N_RESULTS], seq, valid)`.
- No sub-module. All logic is a single `always_ff` with a combinational next-state block.

## Test plan
- **Pairing:** after reset, send 2 beats (d[i]=i+1, then d[i]=0x3FFFFF) with `m_axis_tready`=1.
  - Required: one word with [127]=1, [126:112]=0, [21:0]=1; and [255]=1, [254:240]=1, [237:216]=0x3FFFFF.
  - Required: tlast=0.
- **Burst tlast:** BURST_WORDS=4, send 8 beats. Required: tlast on the 4th word only, with no bubbles in `s_axis_tready`.
- **Flush:**
  - 1 beat, then `flush` 3 cycles later. Required: word with upper 128 bits = 0, tlast=1, and the burst counter resets (next burst full length).
  - Flush pulse in EMPTY: no output.
- **Timeout:** FLUSH_TIMEOUT=8, 1 beat, then idle. Required: tvalid rises exactly 9 cycles after the beat handshake.
- **Backpressure and collisions:**
  - Hold `m_axis_tready`=0 with a word pending, then pulse `flush` in HALF. Required: `flush_pend` is set, and the half-word emits 1 cycle after the pending word handshakes.
  - Beat and flush in the same cycle. Required: full word only.
  - Reset mid-HALF: no output, `seq_num`=0.
- **Sequence wrap:** preload via 32768 beats. Required: record seq goes 32767 then 0.
